// File: rtl/fuc_pkg.sv
// Shared types for the fast_unordered_cash backing-memory port:
// FSM state encoding and the write-back buffer entry.
package fuc_pkg;

  localparam int unsigned ADDRESS_SIZE = 16;
  localparam int unsigned DATA_SIZE    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WB_WAIT = 2'd2,
    RESPOND = 2'd3
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [ADDRESS_SIZE-1:0] address;
    logic [DATA_SIZE-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/fuc_write_buffer.sv
// One-entry write-back buffer holding a single evicted word, with an
// address compare against the cache's current fetch address.
module fuc_write_buffer
  import fuc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    clear,
  input  logic [ADDRESS_SIZE-1:0] load_address,
  input  logic [DATA_SIZE-1:0]    load_data,
  input  logic [ADDRESS_SIZE-1:0] fetch_address,
  output wb_entry_t               entry,
  output logic                    match
);

  // Entry register; clear only drops the valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
    end else if (load) begin
      entry <= '{valid: 1'b1, address: load_address, data: load_data};
    end else if (clear) begin
      entry.valid <= 1'b0;
    end else begin
      entry <= entry;
    end
  end

  assign match = entry.valid && (entry.address == fetch_address);

endmodule

// File: rtl/fuc_backing_port.sv
// Backing-memory port for fast_unordered_cash: serves fetches and evictions
// over a req/ack bus, letting fetches overtake a buffered eviction.
module fuc_backing_port
  import fuc_pkg::*;
#(
  parameter int address_size = ADDRESS_SIZE,
  parameter int data_size    = DATA_SIZE,
  parameter int timeout_size = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    unload_valid,
  input  logic [address_size-1:0] unload_address,
  input  logic [data_size-1:0]    unload_data,
  output logic                    unloaded_data_handled,
  input  logic                    request_string,
  input  logic [address_size-1:0] fetch_address,
  output logic [data_size-1:0]    fetch_data,
  output logic                    fetch_data_presented,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [address_size-1:0] mem_address,
  output logic [data_size-1:0]    mem_wdata,
  input  logic [data_size-1:0]    mem_rdata,
  input  logic                    mem_ack,
  output logic                    wb_pending,
  output logic                    timeout_error
);

  // Expiry fires on the cycle that would bring the counter to all-ones.
  localparam logic [timeout_size-1:0] timer_one  = timeout_size'(1);
  localparam logic [timeout_size-1:0] timer_last = ~timer_one;

  state_t                  state;
  wb_entry_t               wb;
  logic                    wb_match;
  logic                    wb_load;
  logic                    wb_clear;
  logic                    timer_expire;
  logic [timeout_size-1:0] timer;

  always_comb begin
    timer_expire = mem_req && !mem_ack && (timer == timer_last);
    wb_load      = (state == IDLE) && unload_valid && !wb.valid;
    wb_clear     = (state == WB_WAIT) && mem_req && (mem_ack || timer_expire);
  end

  fuc_write_buffer u_write_buffer (
    .clk           (clk),
    .reset         (reset),
    .load          (wb_load),
    .clear         (wb_clear),
    .load_address  (unload_address),
    .load_data     (unload_data),
    .fetch_address (fetch_address),
    .entry         (wb),
    .match         (wb_match)
  );

  assign wb_pending = wb.valid;

  // Control FSM with registered bus and cache-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      unloaded_data_handled <= 1'b0;
      fetch_data            <= '0;
      fetch_data_presented  <= 1'b0;
      mem_req               <= 1'b0;
      mem_we                <= 1'b0;
      mem_address           <= '0;
      mem_wdata             <= '0;
      timer                 <= '0;
      timeout_error         <= 1'b0;
    end else begin
      unloaded_data_handled <= 1'b0;
      fetch_data_presented  <= 1'b0;
      case (state)
        IDLE: begin
          if (unload_valid && !wb.valid) begin
            unloaded_data_handled <= 1'b1;
          end else if (request_string && wb_match) begin
            fetch_data           <= wb.data;
            fetch_data_presented <= 1'b1;
            state                <= RESPOND;
          end else if (request_string) begin
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_address <= fetch_address;
            mem_wdata   <= '0;
            state       <= RD_WAIT;
          end else if (wb.valid) begin
            mem_req     <= 1'b1;
            mem_we      <= 1'b1;
            mem_address <= wb.address;
            mem_wdata   <= wb.data;
            state       <= WB_WAIT;
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mem_req              <= 1'b0;
            timer                <= '0;
            fetch_data           <= mem_rdata;
            fetch_data_presented <= 1'b1;
            state                <= RESPOND;
          end else if (timer_expire) begin
            mem_req              <= 1'b0;
            timer                <= '0;
            timeout_error        <= 1'b1;
            fetch_data           <= '0;
            fetch_data_presented <= 1'b1;
            state                <= RESPOND;
          end else begin
            timer <= timer + timer_one;
          end
        end
        WB_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            timer   <= '0;
            state   <= IDLE;
          end else if (timer_expire) begin
            mem_req       <= 1'b0;
            timer         <= '0;
            timeout_error <= 1'b1;
            state         <= IDLE;
          end else begin
            timer <= timer + timer_one;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
